// File: rtl/instr_fetch_if.sv
// Bus bundle between the Divvy fetch stage and its environment
// (sequencer, decoder, ALU condition, instruction ROM, branch-target LUT).
//
// Handshake semantics: Start is a one-cycle request accepted only in IDLE or
// HALTED; there is no ready signal because it is never back-pressured there
// and it is ignored in RUN. Done is high for as long as the core is halted
// and drops on the edge that accepts the next Start. RomRdEn qualifies
// RomAddr; the ROM presents data on RomData one edge later. InstrValid
// qualifies Instr and PC. Stall freezes fetch for the cycle it is high.
interface instr_fetch_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               Start;
    logic               Stall;
    logic               Branch;
    logic               BranchCond;
    logic               Halt;
    logic [PC_W-1:0]    RomAddr;
    logic               RomRdEn;
    logic [INSTR_W-1:0] RomData;
    logic [INSTR_W-1:0] Instr;
    logic               InstrValid;
    logic [PC_W-1:0]    PC;
    logic               Done;
    logic [CNT_W-1:0]   InstrCount;
    logic               LutWrEn;
    logic [3:0]         LutWrAddr;
    logic [PC_W-1:0]    LutWrData;
    logic [1:0]         fsm_state;   // debug view of the sequencer state

    modport slave (
        input  Start, Stall, Branch, BranchCond, Halt, RomData,
               LutWrEn, LutWrAddr, LutWrData,
        output RomAddr, RomRdEn, Instr, InstrValid, PC, Done, InstrCount,
               fsm_state
    );

    modport master (
        output Start, Stall, Branch, BranchCond, Halt, RomData,
               LutWrEn, LutWrAddr, LutWrData,
        input  RomAddr, RomRdEn, Instr, InstrValid, PC, Done, InstrCount,
               fsm_state
    );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and instruction fetch for the Divvy accumulator core.
// Next-PC is combinational so the ROM address for the following instruction
// is issued in the same cycle the current one executes: one instruction per
// cycle, no bubble on taken branches.
module instr_fetch #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic          CLK,
    input  logic          ResetN,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [PC_W-1:0]  pc, pc_nx;
    logic [PC_W-1:0]  rom_addr;
    logic             rom_rd_en;
    logic             instr_valid, valid_nx;
    logic             done, done_nx;
    logic             retire;
    logic             clear_cnt;
    logic             taken;
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  lut [LUT_DEPTH];

    // Sequencer and next-PC selection: Stall beats Halt beats branch beats increment.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        rom_addr  = '0;
        rom_rd_en = 1'b0;
        valid_nx  = instr_valid;
        done_nx   = done;
        retire    = 1'b0;
        clear_cnt = 1'b0;
        taken     = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (bus.Start) begin
                    rom_addr  = '0;
                    rom_rd_en = 1'b1;
                    pc_nx     = '0;
                    clear_cnt = 1'b1;
                    valid_nx  = 1'b1;
                    done_nx   = 1'b0;
                    state_nx  = S_RUN;
                end
            end
            S_RUN: begin
                // Decoder and ALU inputs only matter when Instr is executable.
                if (!instr_valid || bus.Stall) begin
                    rom_rd_en = 1'b0;
                end else if (bus.Halt) begin
                    valid_nx = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_HALTED;
                end else begin
                    taken     = bus.Branch & bus.BranchCond;
                    pc_nx     = taken ? lut[bus.RomData[3:0]] : pc + PC_W'(1);
                    rom_addr  = pc_nx;
                    rom_rd_en = 1'b1;
                    retire    = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Sequencer state, PC and status registers.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr_valid <= valid_nx;
            done        <= done_nx;
        end
    end

    // Retired-instruction counter, cleared by Start and saturating at all-ones.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            count <= '0;
        end else if (clear_cnt) begin
            count <= '0;
        end else if (retire && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    // Branch-target LUT; writes are locked out while the program is running.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (bus.LutWrEn && (state != S_RUN)) begin
            lut[bus.LutWrAddr] <= bus.LutWrData;
        end
    end

    // ROM request is forced quiet while reset is held, independent of the clock.
    assign bus.RomAddr    = ResetN ? rom_addr : '0;
    assign bus.RomRdEn    = ResetN & rom_rd_en;
    assign bus.Instr      = bus.RomData;
    assign bus.InstrValid = instr_valid;
    assign bus.PC         = pc;
    assign bus.Done       = done;
    assign bus.InstrCount = count;
    assign bus.fsm_state  = state;

endmodule
